// File: rtl/glove_pkg.sv
// Shared types, dimensions and saturation helpers for the glove sensor front end.
package glove_pkg;

    localparam int unsigned N_CH     = 8;
    localparam int unsigned N_STEP   = 5;
    localparam int unsigned HOP      = 1;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned N_VAL    = N_CH * N_STEP;
    localparam int unsigned CH_W     = $clog2(N_CH);
    localparam int unsigned FILL_W   = $clog2(N_STEP + 1);
    localparam int unsigned HOP_W    = $clog2(N_STEP + 1);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    // Full-precision difference of two samples; never overflows.
    function automatic logic signed [SAMPLE_W:0] sub17(input sample_t a, input sample_t b);
        return $signed({a[SAMPLE_W-1], a}) - $signed({b[SAMPLE_W-1], b});
    endfunction

    // Clamp a 17-bit signed value into the sample range.
    function automatic sample_t sat16(input logic signed [SAMPLE_W:0] d);
        if (d[SAMPLE_W] != d[SAMPLE_W-1]) begin
            return d[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
        end
        return sample_t'(d[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/baseline_sub.sv
// Per-channel calibration baseline storage and saturating baseline subtraction.
module baseline_sub
    import glove_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [CH_W-1:0] ch,
    input  sample_t         sample,
    input  logic            capture,
    output sample_t         diff_c
);

    sample_t base [N_CH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            base <= '{default: '0};
        end else if (capture) begin
            base[ch] <= sample;
        end
    end

    assign diff_c = sat16(sub17(sample, base[ch]));

endmodule

// File: rtl/frame_assembler.sv
// Collects the serial sensor stream into a sliding window of steps and hands
// baseline-corrected frames to the recognition core over valid/ready.
module frame_assembler
    import glove_pkg::*;
(
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  sample_t                          i_sample,
    input  logic                             i_valid,
    input  logic                             i_sof,
    input  logic                             i_calib,
    input  logic                             i_flush,
    input  logic                             i_ready,
    output logic [N_VAL-1:0][SAMPLE_W-1:0]   o_data,
    output logic                             o_valid,
    output logic                             o_overrun,
    output logic                             o_sync_err,
    output logic                             o_calibrated,
    output logic [FILL_W-1:0]                o_fill
);

    localparam int unsigned HIST_N = N_VAL - N_CH;

    logic [CH_W-1:0]                ch_cnt;
    logic [HOP_W-1:0]               hop_cnt;
    logic                           cal_pend;
    logic                           cal_active;
    logic [N_CH-1:0][SAMPLE_W-1:0]  step_buf;
    // Newest N_STEP-1 completed steps; the oldest is dropped on every shift anyway.
    logic [HIST_N-1:0][SAMPLE_W-1:0] hist;

    logic                           accept;
    logic                           resync;
    logic                           cal_now;
    logic                           last_ch;
    logic                           step_done;
    logic                           cal_done;
    logic                           emit;
    logic [CH_W-1:0]                eff_ch;
    sample_t                        diff_c;
    logic [N_CH-1:0][SAMPLE_W-1:0]  step_new;
    logic [N_VAL-1:0][SAMPLE_W-1:0] window_next;
    logic [FILL_W-1:0]              fill_next;
    logic [HOP_W-1:0]               hop_next;

    baseline_sub u_baseline (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .ch      (eff_ch),
        .sample  (i_sample),
        .capture (accept && cal_now),
        .diff_c  (diff_c)
    );

    // Channel alignment, step completion and emit decision for this cycle.
    always_comb begin
        accept      = i_valid && !i_flush;
        resync      = accept && i_sof && (ch_cnt != '0);
        eff_ch      = i_sof ? '0 : ch_cnt;
        cal_now     = (eff_ch == '0) ? cal_pend : cal_active;
        last_ch     = (eff_ch == CH_W'(N_CH - 1));
        step_done   = accept && last_ch && !cal_now;
        cal_done    = accept && last_ch && cal_now;
        step_new    = step_buf;
        step_new[N_CH-1] = diff_c;
        window_next = {step_new, hist};
        fill_next   = (o_fill == FILL_W'(N_STEP)) ? o_fill : o_fill + FILL_W'(1);
        hop_next    = hop_cnt + HOP_W'(1);
        // The first full window always emits; afterwards every HOP steps.
        emit        = step_done && (fill_next == FILL_W'(N_STEP)) &&
                      ((o_fill != FILL_W'(N_STEP)) || (hop_next == HOP_W'(HOP)));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ch_cnt       <= '0;
            hop_cnt      <= '0;
            cal_pend     <= 1'b0;
            cal_active   <= 1'b0;
            step_buf     <= '0;
            hist         <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_overrun    <= 1'b0;
            o_sync_err   <= 1'b0;
            o_calibrated <= 1'b0;
            o_fill       <= '0;
        end else begin
            o_overrun  <= 1'b0;
            o_sync_err <= resync;

            if (cal_done) begin
                cal_pend     <= 1'b0;
                o_calibrated <= 1'b1;
            end
            if (i_calib) begin
                cal_pend <= 1'b1;
            end

            if (i_flush) begin
                ch_cnt  <= '0;
                hop_cnt <= '0;
                o_fill  <= '0;
                o_valid <= 1'b0;
            end else begin
                if (accept) begin
                    ch_cnt           <= last_ch ? '0 : eff_ch + CH_W'(1);
                    step_buf[eff_ch] <= diff_c;
                    if (eff_ch == '0) begin
                        cal_active <= cal_pend;
                    end
                end
                if (step_done) begin
                    hist    <= window_next[N_VAL-1:N_CH];
                    o_fill  <= fill_next;
                    hop_cnt <= emit ? '0 : hop_next;
                end
                // A fresh frame wins over the handshake; an unconsumed one is overwritten.
                if (emit) begin
                    o_data    <= window_next;
                    o_valid   <= 1'b1;
                    o_overrun <= o_valid && !i_ready;
                end else if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler with a queue-based reference model checked every cycle.
module tb_frame_assembler;
    import glove_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst_n;
    sample_t                        sample;
    logic                           valid, sof, calib, flush, ready;
    logic [N_VAL-1:0][SAMPLE_W-1:0] data;
    logic                           o_valid, o_overrun, o_sync_err, o_calibrated;
    logic [FILL_W-1:0]              o_fill;

    frame_assembler dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sample     (sample),
        .i_valid      (valid),
        .i_sof        (sof),
        .i_calib      (calib),
        .i_flush      (flush),
        .i_ready      (ready),
        .o_data       (data),
        .o_valid      (o_valid),
        .o_overrun    (o_overrun),
        .o_sync_err   (o_sync_err),
        .o_calibrated (o_calibrated),
        .o_fill       (o_fill)
    );

    int checks = 0;
    int fails  = 0;
    int ovr_cnt  = 0;
    int serr_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int dval(input int idx);
        return int'($signed(data[idx]));
    endfunction

    // Reference model: window and partial step as queues of corrected values.
    // With HOP of 1 every step that leaves the window full produces a frame.
    int m_win[$];
    int m_part[$];
    int m_base[N_CH];
    int m_data[N_VAL];
    bit m_cal_pend, m_cal_step, m_calibrated, m_valid, m_ovr, m_serr;

    always @(posedge clk) begin
        bit emitted, hs;
        emitted = 1'b0;
        hs      = 1'b0;
        if (!rst_n) begin
            m_win.delete();
            m_part.delete();
            m_base       = '{default: 0};
            m_data       = '{default: 0};
            m_cal_pend   = 1'b0;
            m_cal_step   = 1'b0;
            m_calibrated = 1'b0;
            m_valid      = 1'b0;
            m_ovr        = 1'b0;
            m_serr       = 1'b0;
        end else begin
            m_ovr  = 1'b0;
            m_serr = 1'b0;
            if (flush) begin
                m_win.delete();
                m_part.delete();
                m_valid = 1'b0;
            end else begin
                hs = m_valid && ready;
                if (valid) begin
                    if (sof && m_part.size() != 0) begin
                        m_serr = 1'b1;
                        m_part.delete();
                    end
                    if (m_part.size() == 0) m_cal_step = m_cal_pend;
                    if (m_cal_step) m_part.push_back(int'(sample));
                    else m_part.push_back(sat(int'(sample) - m_base[m_part.size()]));
                    if (m_part.size() == int'(N_CH)) begin
                        if (m_cal_step) begin
                            for (int i = 0; i < int'(N_CH); i++) m_base[i] = m_part[i];
                            m_cal_pend   = 1'b0;
                            m_calibrated = 1'b1;
                        end else begin
                            foreach (m_part[i]) m_win.push_back(m_part[i]);
                            while (m_win.size() > int'(N_VAL)) void'(m_win.pop_front());
                            emitted = (m_win.size() == int'(N_VAL));
                        end
                        m_part.delete();
                    end
                end
                if (emitted) begin
                    m_ovr   = m_valid && !ready;
                    m_valid = 1'b1;
                    for (int i = 0; i < int'(N_VAL); i++) m_data[i] = m_win[i];
                end else if (hs) begin
                    m_valid = 1'b0;
                end
            end
            if (calib) m_cal_pend = 1'b1;
        end
    end

    // Compare DUT against model shortly after every active edge.
    always @(posedge clk) begin
        #1;
        if (o_overrun)  ovr_cnt++;
        if (o_sync_err) serr_cnt++;
        check("o_valid",      int'(o_valid),      int'(m_valid));
        check("o_fill",       int'(o_fill),       m_win.size() / int'(N_CH));
        check("o_overrun",    int'(o_overrun),    int'(m_ovr));
        check("o_sync_err",   int'(o_sync_err),   int'(m_serr));
        check("o_calibrated", int'(o_calibrated), int'(m_calibrated));
        if (m_valid) begin
            int bad;
            bad = -1;
            for (int i = 0; i < int'(N_VAL); i++)
                if (bad < 0 && dval(i) != m_data[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL o_data[%0d]: got %0d, expected %0d at %0t",
                         bad, dval(bad), m_data[bad], $time);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0; sof = 1'b0; calib = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic put(input int v, input bit s);
        @(negedge clk);
        valid = 1'b1; sof = s; sample = sample_t'(v); calib = 1'b0; flush = 1'b0;
    endtask

    task automatic send_vals(input int v[N_CH]);
        for (int c = 0; c < int'(N_CH); c++) put(v[c], c == 0);
        idle(1);
    endtask

    task automatic send_step(input int base);
        int v[N_CH];
        for (int c = 0; c < int'(N_CH); c++) v[c] = base + c;
        send_vals(v);
    endtask

    task automatic pulse_calib();
        @(negedge clk);
        valid = 1'b0; sof = 1'b0; calib = 1'b1; flush = 1'b0;
        idle(1);
    endtask

    initial begin
        int vals[N_CH];
        int snap;
        rst_n = 1'b0; sample = '0; valid = 1'b0; sof = 1'b0;
        calib = 1'b0; flush = 1'b0; ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        check("reset o_valid", int'(o_valid), 0);
        check("reset o_fill",  int'(o_fill), 0);

        // Fill
        for (int s = 0; s < 4; s++) send_step(s * 100);
        check("fill4 o_valid", int'(o_valid), 0);
        send_step(400);
        check("fill o_valid", int'(o_valid), 1);
        check("fill o_data[0]", dval(0), 0);
        check("fill o_data[39]", dval(39), 407);
        check("fill o_fill", int'(o_fill), 5);
        idle(1);
        check("fill handshake drop", int'(o_valid), 0);

        // Slide
        send_step(500);
        check("slide o_data[0]", dval(0), 100);
        check("slide o_data[39]", dval(39), 507);
        idle(1);

        // Backpressure
        ready = 1'b0;
        snap = ovr_cnt;
        send_step(600);
        check("bp step6 o_data[39]", dval(39), 607);
        send_step(700);
        check("bp o_overrun", int'(o_overrun), 1);
        check("bp o_data[39]", dval(39), 707);
        check("bp overrun count", ovr_cnt - snap, 1);
        ready = 1'b1;
        idle(1);
        check("bp o_valid after handshake", int'(o_valid), 0);
        check("bp overrun pulse width", int'(o_overrun), 0);

        // Resync
        snap = serr_cnt;
        put(800, 1'b1); put(801, 1'b0); put(802, 1'b0);
        put(900, 1'b1);
        for (int c = 1; c < int'(N_CH); c++) put(900 + c, 1'b0);
        idle(1);
        check("resync sync_err count", serr_cnt - snap, 1);
        check("resync o_fill", int'(o_fill), 5);
        check("resync o_data[32]", dval(32), 900);
        check("resync o_data[39]", dval(39), 907);
        check("resync o_data[31]", dval(31), 707);
        idle(1);

        // Calibration
        pulse_calib();
        vals = '{default: 1000};
        send_vals(vals);
        check("cal o_calibrated", int'(o_calibrated), 1);
        check("cal o_fill", int'(o_fill), 5);
        check("cal no frame", int'(o_valid), 0);
        send_step(1000);
        check("cal o_data[32]", dval(32), 0);
        check("cal o_data[39]", dval(39), 7);
        check("cal o_data[31]", dval(31), 907);
        idle(1);
        pulse_calib();
        vals = '{default: 0};
        vals[0] = -100; vals[1] = 100;
        send_vals(vals);
        vals[0] = 32767; vals[1] = -32768; vals[2] = 5;
        send_vals(vals);
        check("sat hi o_data[32]", dval(32), 32767);
        check("sat lo o_data[33]", dval(33), -32768);
        check("sat o_data[34]", dval(34), 5);
        idle(1);

        // Flush and reset
        ready = 1'b0;
        send_step(2000);
        check("flush pre o_valid", int'(o_valid), 1);
        check("flush pre o_data[39]", dval(39), 2007);
        @(negedge clk);
        valid = 1'b1; sof = 1'b1; sample = sample_t'(55); flush = 1'b1;
        idle(1);
        check("flush o_valid", int'(o_valid), 0);
        check("flush o_fill", int'(o_fill), 0);
        check("flush o_calibrated", int'(o_calibrated), 1);
        put(3000, 1'b1); put(3001, 1'b0); put(3002, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b1; sof = 1'b0; sample = sample_t'(3003);
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b0;
        check("rst o_calibrated", int'(o_calibrated), 0);
        check("rst o_fill", int'(o_fill), 0);
        check("rst o_valid", int'(o_valid), 0);
        ready = 1'b1;
        for (int s = 0; s < 4; s++) send_step(4000 + s * 100);
        check("refill4 o_valid", int'(o_valid), 0);
        check("refill4 o_fill", int'(o_fill), 4);
        send_step(4400);
        check("refill o_valid", int'(o_valid), 1);
        check("refill o_data[0]", dval(0), 4000);
        check("refill o_data[39]", dval(39), 4407);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
